soc_cops_sqrt_queue_axi: RTL and testbench

- AXI4 single-beat slave front-end for a pipelined square-root coprocessor core (COPS family) that supports up to DEPTH outstanding operations and queues results in a DEPTH-entry FIFO.
- Successor to the single-operation wrapper. Operand writes are non-blocking, with a credit check. Adds a control register (flush, error clear), sticky error reporting, address-decode errors and parametrised widths.
- Sits on the uncached SoC peripheral crossbar.
- The square-root core is external and connects through the core_* ports. The core has no backpressure and a fixed, unknown latency of at least 1 cycle.

---
 rtl/soc_cops_sqrt_queue_axi.sv | 244 ++++++++++++++++++++++++
 tb/tb_soc_cops_sqrt_queue_axi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_cops_sqrt_queue_axi.sv
// AXI4 single-beat slave front-end for a pipelined square-root core: non-blocking
// operand writes gated by a credit check, DEPTH-entry result FIFO, flush and sticky error.
//   state  | meaning
//   W_IDLE | wait for aw+w together; DATA writes stall without credit
//   W_ACK  | one-cycle awready/wready, apply the write effect
//   W_RESP | hold bvalid until bready
//   R_IDLE | arready high, capture read result on arvalid
//   R_DATA | hold rvalid until rready
module soc_cops_sqrt_queue_axi #(
  parameter logic [31:0] BASE_ADDR = 32'h1FD004F0,
  parameter int          ID_W      = 4,
  parameter int          IN_W      = 32,
  parameter int          OUT_W     = 24,
  parameter int          DEPTH     = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [ID_W-1:0]  axi_s_awid,
  input  logic [31:0]      axi_s_awaddr,
  input  logic [7:0]       axi_s_awlen,
  input  logic [2:0]       axi_s_awsize,
  input  logic [1:0]       axi_s_awburst,
  input  logic             axi_s_awuser,
  input  logic             axi_s_awvalid,
  output logic             axi_s_awready,
  input  logic [31:0]      axi_s_wdata,
  input  logic [3:0]       axi_s_wstrb,
  input  logic             axi_s_wlast,
  input  logic             axi_s_wvalid,
  output logic             axi_s_wready,
  output logic [ID_W-1:0]  axi_s_bid,
  output logic [1:0]       axi_s_bresp,
  output logic             axi_s_bvalid,
  input  logic             axi_s_bready,
  input  logic [ID_W-1:0]  axi_s_arid,
  input  logic [31:0]      axi_s_araddr,
  input  logic [7:0]       axi_s_arlen,
  input  logic [2:0]       axi_s_arsize,
  input  logic [1:0]       axi_s_arburst,
  input  logic             axi_s_aruser,
  input  logic             axi_s_arvalid,
  output logic             axi_s_arready,
  output logic [ID_W-1:0]  axi_s_rid,
  output logic [31:0]      axi_s_rdata,
  output logic [1:0]       axi_s_rresp,
  output logic             axi_s_rlast,
  output logic             axi_s_rvalid,
  input  logic             axi_s_rready,
  output logic [IN_W-1:0]  core_in_tdata,
  output logic             core_in_tvalid,
  input  logic [OUT_W-1:0] core_out_tdata,
  input  logic             core_out_tvalid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {A_DATA, A_STATUS, A_CTRL, A_NONE} addr_kind_t;

  function automatic addr_kind_t decode(input logic [31:0] a);
    if (a == BASE_ADDR)               return A_DATA;
    else if (a == BASE_ADDR + 32'h4)  return A_STATUS;
    else if (a == BASE_ADDR + 32'h8)  return A_CTRL;
    else                              return A_NONE;
  endfunction

  w_state_t         w_state;
  r_state_t         r_state;
  addr_kind_t       w_kind, aw_kind, ar_kind;
  logic [31:0]      w_data_q;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, inflight, discard;
  logic             err;
  logic             empty, full, credit_ok, ar_accept, pop, rd_empty_err;
  logic             flush, clr_err, res_drop, push, full_drop;
  logic [31:0]      head_ext, status;
  logic             unused_inputs;

  assign unused_inputs = ^{axi_s_awlen, axi_s_awsize, axi_s_awburst, axi_s_awuser, axi_s_wstrb,
                           axi_s_wlast, axi_s_arlen, axi_s_arsize, axi_s_arburst, axi_s_aruser};

  assign aw_kind   = decode(axi_s_awaddr);
  assign ar_kind   = decode(axi_s_araddr);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < {1'b0, DEPTH_C};

  assign axi_s_arready = (r_state == R_IDLE);
  assign axi_s_rlast   = 1'b1;
  assign ar_accept     = (r_state == R_IDLE) && axi_s_arvalid;
  assign pop           = ar_accept && (ar_kind == A_DATA) && !empty;
  assign rd_empty_err  = ar_accept && (ar_kind == A_DATA) && empty;

  assign flush     = (w_state == W_ACK) && (w_kind == A_CTRL) && w_data_q[0];
  assign clr_err   = (w_state == W_ACK) && (w_kind == A_CTRL) && w_data_q[1];
  assign res_drop  = core_out_tvalid && (discard != '0);
  // A result arriving alongside a flush is consumed by the flush itself.
  assign push      = core_out_tvalid && !res_drop && !flush && (!full || pop);
  assign full_drop = core_out_tvalid && !res_drop && !flush && full && !pop;

  always_comb begin
    head_ext = '0;
    head_ext[OUT_W-1:0] = mem[rd_ptr];
  end

  always_comb begin
    status = '0;
    status[0] = !empty;
    status[1] = full;
    status[2] = err;
    status[8 +: CW]  = count;
    status[16 +: CW] = inflight;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state        <= W_IDLE;
      w_kind         <= A_NONE;
      w_data_q       <= '0;
      axi_s_awready  <= 1'b0;
      axi_s_wready   <= 1'b0;
      axi_s_bvalid   <= 1'b0;
      axi_s_bid      <= '0;
      axi_s_bresp    <= RESP_OKAY;
      core_in_tvalid <= 1'b0;
      core_in_tdata  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi_s_awvalid && axi_s_wvalid && (aw_kind != A_DATA || credit_ok)) begin
            w_kind         <= aw_kind;
            w_data_q       <= axi_s_wdata;
            axi_s_bid      <= axi_s_awid;
            axi_s_awready  <= 1'b1;
            axi_s_wready   <= 1'b1;
            core_in_tvalid <= (aw_kind == A_DATA);
            core_in_tdata  <= axi_s_wdata[IN_W-1:0];
            w_state        <= W_ACK;
          end
        end
        W_ACK: begin
          axi_s_awready  <= 1'b0;
          axi_s_wready   <= 1'b0;
          core_in_tvalid <= 1'b0;
          axi_s_bvalid   <= 1'b1;
          case (w_kind)
            A_DATA, A_CTRL: axi_s_bresp <= RESP_OKAY;
            A_STATUS:       axi_s_bresp <= RESP_SLVERR;
            default:        axi_s_bresp <= RESP_DECERR;
          endcase
          w_state <= W_RESP;
        end
        W_RESP: begin
          if (axi_s_bready) begin
            axi_s_bvalid <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= R_IDLE;
      axi_s_rvalid <= 1'b0;
      axi_s_rid    <= '0;
      axi_s_rdata  <= '0;
      axi_s_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi_s_arvalid) begin
            axi_s_rid    <= axi_s_arid;
            axi_s_rvalid <= 1'b1;
            r_state      <= R_DATA;
            case (ar_kind)
              A_DATA: begin
                axi_s_rdata <= empty ? 32'h0 : head_ext;
                axi_s_rresp <= empty ? RESP_SLVERR : RESP_OKAY;
              end
              A_STATUS: begin
                axi_s_rdata <= status;
                axi_s_rresp <= RESP_OKAY;
              end
              A_CTRL: begin
                axi_s_rdata <= 32'h0;
                axi_s_rresp <= RESP_OKAY;
              end
              default: begin
                axi_s_rdata <= 32'h0;
                axi_s_rresp <= RESP_DECERR;
              end
            endcase
          end
        end
        R_DATA: begin
          if (axi_s_rready) begin
            axi_s_rvalid <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      err      <= 1'b0;
    end else begin
      inflight <= inflight + CW'(core_in_tvalid) - CW'(core_out_tvalid);
      if (flush)         discard <= inflight - CW'(core_out_tvalid);
      else if (res_drop) discard <= discard - CW'(1);
      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
      if (rd_empty_err || full_drop) err <= 1'b1;
      else if (clr_err)              err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= core_out_tdata;
  end

endmodule

// File: tb/tb_soc_cops_sqrt_queue_axi.sv
// Self-checking bench for soc_cops_sqrt_queue_axi with a latency-5 integer square-root core model.
module tb_soc_cops_sqrt_queue_axi;

  localparam logic [31:0] BASE = 32'h1FD004F0;
  localparam logic [31:0] A_DATA = BASE, A_STAT = BASE + 32'h4, A_CTRL = BASE + 32'h8;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic clk = 1'b0, resetn;
  logic [3:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic awvalid, wvalid, arvalid, bready, rready;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0] bresp, rresp;
  logic [31:0] core_in_tdata;
  logic core_in_tvalid, core_out_tvalid;
  logic [23:0] core_out_tdata;

  always #5 clk = ~clk;

  soc_cops_sqrt_queue_axi dut (
    .clk(clk), .resetn(resetn),
    .axi_s_awid(awid), .axi_s_awaddr(awaddr), .axi_s_awlen(8'h0), .axi_s_awsize(3'h2),
    .axi_s_awburst(2'b01), .axi_s_awuser(1'b0), .axi_s_awvalid(awvalid), .axi_s_awready(awready),
    .axi_s_wdata(wdata), .axi_s_wstrb(4'hF), .axi_s_wlast(1'b1), .axi_s_wvalid(wvalid),
    .axi_s_wready(wready),
    .axi_s_bid(bid), .axi_s_bresp(bresp), .axi_s_bvalid(bvalid), .axi_s_bready(bready),
    .axi_s_arid(arid), .axi_s_araddr(araddr), .axi_s_arlen(8'h0), .axi_s_arsize(3'h2),
    .axi_s_arburst(2'b01), .axi_s_aruser(1'b0), .axi_s_arvalid(arvalid), .axi_s_arready(arready),
    .axi_s_rid(rid), .axi_s_rdata(rdata), .axi_s_rresp(rresp), .axi_s_rlast(rlast),
    .axi_s_rvalid(rvalid), .axi_s_rready(rready),
    .core_in_tdata(core_in_tdata), .core_in_tvalid(core_in_tvalid),
    .core_out_tdata(core_out_tdata), .core_out_tvalid(core_out_tvalid)
  );

  function automatic logic [23:0] isqrt(input logic [31:0] v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(v)) r++;
    return 24'(r);
  endfunction

  logic [24:0] pipe [5];
  always @(posedge clk) begin
    pipe[0] <= {core_in_tvalid, isqrt(core_in_tdata)};
    for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out_tvalid = pipe[4][24];
  assign core_out_tdata  = pipe[4][23:0];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tfail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp;} rexp_t;
  bexp_t bq[$];
  rexp_t rq[$];

  always @(negedge clk) begin : mon_b
    bexp_t e;
    if (resetn && bvalid && bready) begin
      if (bq.size() == 0) tfail("b_unexpected");
      else begin
        e = bq.pop_front();
        chk("bid", 32'(bid), 32'(e.id));
        chk("bresp", 32'(bresp), 32'(e.resp));
      end
    end
  end

  always @(negedge clk) begin : mon_r
    rexp_t e;
    if (resetn && rvalid && rready) begin
      if (rq.size() == 0) tfail("r_unexpected");
      else begin
        e = rq.pop_front();
        chk("rid", 32'(rid), 32'(e.id));
        chk("rdata", rdata, e.data);
        chk("rresp", 32'(rresp), 32'(e.resp));
        chk("rlast", 32'(rlast), 32'd1);
      end
    end
  end

  // Called and returns at posedge+1; lat = cycles from valids driven to bvalid seen.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] id,
                          input logic [1:0] resp, output int lat);
    bexp_t e;
    int n;
    logic hs;
    e.id = id; e.resp = resp;
    bq.push_back(e);
    awaddr = addr; awid = id; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    lat = -1; hs = 1'b0; n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (bvalid && lat < 0) lat = n;
      if (awready) hs = 1'b1;
      @(posedge clk); #1;
      if (hs) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (lat >= 0) break;
      n++;
    end
    if (lat < 0) begin
      tfail("b_timeout");
      awvalid = 1'b0; wvalid = 1'b0;
      bq.delete();
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                         input logic [1:0] resp);
    rexp_t e;
    int n;
    e.id = id; e.data = data; e.resp = resp;
    rq.push_back(e);
    araddr = addr; arid = id; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 300) begin @(negedge clk); n++; end
    if (!arready) tfail("ar_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (rq.size() != 0) begin tfail("r_timeout"); rq.delete(); end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    int          wait_cyc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] id, input logic [1:0] r, input int wc);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.id = id; v.resp = r; v.wait_cyc = wc;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic stall;
    int n;

    // write: data = wdata; read: data = expected rdata
    add(1, A_DATA, 32'h90, 4'h1, OKAY,   8);
    add(0, A_DATA, 32'hC,  4'h2, OKAY,   0);
    add(0, A_STAT, 32'h0,  4'h3, OKAY,   0);
    add(0, A_DATA, 32'h0,  4'h4, SLVERR, 0);
    add(0, A_STAT, 32'h4,  4'h5, OKAY,   0);
    add(1, A_CTRL, 32'h2,  4'h6, OKAY,   0);
    add(0, A_STAT, 32'h0,  4'h7, OKAY,   0);
    add(1, A_DATA, 32'h40, 4'h8, OKAY,   0);
    add(1, A_DATA, 32'h51, 4'h9, OKAY,   0);
    add(1, A_CTRL, 32'h1,  4'hA, OKAY,  10);
    add(0, A_STAT, 32'h0,  4'hB, OKAY,   0);
    add(1, A_DATA, 32'h19, 4'hC, OKAY,   8);
    add(0, A_DATA, 32'h5,  4'hD, OKAY,   0);
    add(0, BASE + 32'hC,  32'h0, 4'hA, DECERR, 0);
    add(1, BASE + 32'h10, 32'h7, 4'h3, DECERR, 0);
    add(1, A_STAT, 32'h3,  4'h5, SLVERR, 0);
    add(0, A_CTRL, 32'h0,  4'h6, OKAY,   0);
    add(0, A_STAT, 32'h0,  4'h7, OKAY,   0);

    resetn = 1'b0;
    awid = '0; awaddr = '0; wdata = '0; awvalid = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_core_in_tvalid", 32'(core_in_tvalid), 0);
    resetn = 1'b1;
    idle(1);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].id, vecs[i].resp, lat);
        chk($sformatf("b_latency_v%0d", i), 32'(lat), 32'd2);
      end else begin
        do_read(vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].resp);
      end
      idle(vecs[i].wait_cyc);
    end

    // Credit limit: four writes fill DEPTH, the fifth stalls until a pop frees a slot.
    do_write(A_DATA, 32'd4,  4'h1, OKAY, lat);
    do_write(A_DATA, 32'd9,  4'h2, OKAY, lat);
    do_write(A_DATA, 32'd16, 4'h3, OKAY, lat);
    do_write(A_DATA, 32'd25, 4'h4, OKAY, lat);
    chk("b_latency_4th", 32'(lat), 32'd2);
    idle(10);
    do_read(A_STAT, 4'h5, 32'h0000_0403, OKAY);
    stall = 1'b0;
    fork
      do_write(A_DATA, 32'd36, 4'h6, OKAY, lat);
      begin
        repeat (8) begin @(negedge clk); if (awready) stall = 1'b1; end
        @(posedge clk); #1;
        chk("stall_awready", 32'(stall), 0);
        do_read(A_DATA, 4'h7, 32'd2, OKAY);
      end
    join
    idle(10);
    do_read(A_DATA, 4'h8, 32'd3, OKAY);
    do_read(A_DATA, 4'h9, 32'd4, OKAY);
    do_read(A_DATA, 4'hA, 32'd5, OKAY);
    do_read(A_DATA, 4'hB, 32'd6, OKAY);
    do_read(A_STAT, 4'hC, 32'h0, OKAY);

    // Asynchronous reset with a queued result and both responses pending.
    do_write(A_DATA, 32'h31, 4'h2, OKAY, lat);
    idle(8);
    bready = 1'b0; rready = 1'b0;
    awaddr = A_STAT; awid = 4'h1; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) tfail("rst_seq_aw_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = A_CTRL; arid = 4'h3; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    idle(2);
    chk("pre_rst_bvalid", 32'(bvalid), 1);
    chk("pre_rst_rvalid", 32'(rvalid), 1);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_bvalid", 32'(bvalid), 0);
    chk("async_rst_rvalid", 32'(rvalid), 0);
    chk("async_rst_arready", 32'(arready), 1);
    idle(2);
    bready = 1'b1; rready = 1'b1;
    resetn = 1'b1;
    idle(1);
    do_read(A_STAT, 4'h4, 32'h0, OKAY);
    do_read(A_DATA, 4'h5, 32'h0, SLVERR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
